// File: rtl/hack_mem_pkg.sv
// Shared map constants, STATUS bit positions and screen-entry type
// for the Hack data-memory responder.
package hack_mem_pkg;

    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;
    localparam logic [14:0] STATUS_ADDR = 15'h6001;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_KBD   = 2;
    localparam int ST_CNT   = 4;
    localparam int ST_OVF   = 15;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } scr_entry_t;

endpackage

// File: rtl/hack_scr_fifo.sv
// Screen write buffer: synchronous FIFO whose head is read straight
// out of the storage flops, forced to zero while empty.
module hack_scr_fifo
    import hack_mem_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  scr_entry_t   entry_i,
    input  logic         pop_i,
    output scr_entry_t   head_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    scr_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = cnt_q == FULL_CNT;
    assign empty_o = cnt_q == '0;
    assign valid_o = ~empty_o;
    assign count_o = cnt_q;

    // Fullness is judged on the pre-edge count, so a pop never frees a slot early.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_o = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= entry_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data-memory responder: RAM, buffered screen port,
// keyboard latch and STATUS register, with zero-latency reads.
module hack_data_mem
    import hack_mem_pkg::*;
#(
    parameter int RAM_AW  = 8,
    parameter int FIFO_AW = 2
) (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    output logic        scr_valid,
    input  logic        scr_ready,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    input  logic [15:0] kbd_data
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic is_ram, is_scr, is_kbd, is_stat;

    assign is_ram  = ~addressM[14];
    assign is_scr  = addressM[14:13] == SCREEN_BASE[14:13];
    assign is_kbd  = addressM == KBD_ADDR;
    assign is_stat = addressM == STATUS_ADDR;

    logic [15:0] ram_q [RAM_DEPTH];

    always_ff @(posedge clock) begin
        if (writeM && is_ram) begin
            ram_q[addressM[RAM_AW-1:0]] <= outM;
        end
    end

    scr_entry_t       push_ent, head;
    logic             scr_push;
    logic             fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_cnt;

    assign scr_push = writeM & is_scr;
    assign push_ent = '{addr: addressM[12:0], data: outM};

    hack_scr_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (scr_push),
        .entry_i (push_ent),
        .pop_i   (scr_ready),
        .head_o  (head),
        .valid_o (scr_valid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign scr_addr = head.addr;
    assign scr_data = head.data;

    logic        kbd_full_q, kbd_full_d;
    logic [15:0] kbd_code_q, kbd_code_d;
    logic        ovf_q, ovf_d;
    logic        kbd_cap;

    assign kbd_ready = ~kbd_full_q;
    assign kbd_cap   = kbd_valid & ~kbd_full_q;

    // Capture beats a CPU clear; a fresh overflow beats a STATUS clear.
    always_comb begin
        kbd_full_d = kbd_full_q;
        kbd_code_d = kbd_code_q;
        ovf_d      = ovf_q;
        if (kbd_cap) begin
            kbd_full_d = 1'b1;
            kbd_code_d = kbd_data;
        end else if (writeM && is_kbd) begin
            kbd_full_d = 1'b0;
            kbd_code_d = '0;
        end
        if (writeM && is_stat && outM[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (scr_push && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kbd_full_q <= 1'b0;
            kbd_code_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            kbd_full_q <= kbd_full_d;
            kbd_code_q <= kbd_code_d;
            ovf_q      <= ovf_d;
        end
    end

    logic [15:0] status;

    always_comb begin
        status                        = '0;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_KBD]                = kbd_full_q;
        status[ST_CNT +: FIFO_AW + 1] = fifo_cnt;
        status[ST_OVF]                = ovf_q;
    end

    always_comb begin
        inM = '0;
        if (is_ram) begin
            inM = ram_q[addressM[RAM_AW-1:0]];
        end else if (is_kbd) begin
            inM = kbd_code_q;
        end else if (is_stat) begin
            inM = status;
        end
    end

endmodule
